display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Downstream consumer of the 4-bit Avalon PIO display output. It treats every change of the PIO nibble as a new hex digit and shifts it into a DIGITS-deep scrolling buffer. It time-multiplexes the buffer onto a common-anode 7-segment bank as active-low segments and digit enables, with anti-ghost blanking. It sits between the PIO's out_port and the board display pins.

## Interface

Parameters:
- DIGITS, 4, number of physical digits; legal range 1..8.
- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ 2.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- nibble_in  in  4  hex value from the PIO out_port.
- clear  in  1  synchronous buffer clear, one-cycle pulse or level.
- seg_n  out  7  active-low segments; bit0 = a … bit6 = g.
- dig_n  out  DIGITS  active-low digit enables; at most one bit low.
- digit_count  out  clog2(DIGITS+1)  number of valid buffered digits.

## Operation

- State:
  - nibble_q (4b): last sampled input.
  - digit[0..DIGITS-1] (4b each): digit 0 is newest.
  - valid[0..DIGITS-1].
  - prescaler (0..SCAN_DIV-1).
  - scan_idx (0..DIGITS-1).
  - Registered outputs.
- Reset values:
  - nibble_q = 0. This matches the PIO reset value, so there is no spurious push.
  - All digits = 0, all valid = 0.
  - prescaler = 0, scan_idx = 0.
  - seg_n = 7'h7F, dig_n = all ones, digit_count = 0.
- Push: in any cycle with nibble_in != nibble_q, the edge performs:
  - digit[0] ← nibble_in, digit[i] ← digit[i-1].
  - valid shifts the same way, with valid[0] ← 1.
  - The oldest digit falls off.
- nibble_q ← nibble_in every cycle.
- A held value produces exactly one push. Writing the same value twice produces no second push.
- digit_count increments on push and saturates at DIGITS.
- Clear: all valid ← 0, all digits ← 0, digit_count ← 0.
  - Clear has priority over a simultaneous push; that push is dropped.
  - nibble_q still updates, so the dropped change is not replayed.
- Scan:
  - prescaler increments every cycle and wraps at SCAN_DIV-1 → 0.
  - On wrap, scan_idx ← (scan_idx+1) mod DIGITS.
- Output register, evaluated on each edge from pre-edge state:
  - dig_n: if prescaler == 0, all ones (blanking cycle). Otherwise bit scan_idx = 0 and all other bits = 1.
  - seg_n: if valid[scan_idx] is set, decode(digit[scan_idx]); otherwise 7'h7F (blank).
- Decode (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- DIGITS = 1: scan_idx is constant 0; a push replaces the single digit.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- Push latency:
  - A change present in cycle N is in the buffer after edge N.
  - It appears on seg_n after edge N+1, provided its position is being scanned and prescaler ≠ 0.
- Slot timing:
  - Each slot lasts SCAN_DIV cycles: 1 blanking cycle followed by SCAN_DIV-1 enabled cycles.
  - A full frame is DIGITS × SCAN_DIV cycles.
- A push mid-slot causes digits to shift positions. The displayed value updates on the next output edge; no extra blanking is inserted.
- Reset asserted mid-operation: at the next edge, all state and outputs take their reset values regardless of other inputs. The scan restarts at slot 0 with its blanking cycle.
- digit_count updates on the same edge as the push or clear.

## Test plan

Use DIGITS=4, SCAN_DIV=4.

1. Reset with nibble_in=0, then run 32 cycles -> seg_n stays 7F and digit_count=0. dig_n cycles F,E,E,E,F,D,D,D,F,B,… (blank first cycle of each slot).
2. Drive nibble_in 0→3, hold 10 cycles, then →7 -> digit_count=2. In slot 0 enabled cycles, seg_n=78; in slot 1, seg_n=30; in slots 2–3, seg_n=7F.
3. Hold nibble_in=5 for 100 cycles after one change -> exactly one push (digit_count=1). Then apply changes to 1,2,3,4,6 -> digit_count saturates at 4. Buffer reads 6,4,3,2; 5 and 1 are dropped.
4. Assert clear in the same cycle nibble_in changes 2→9 -> digit_count=0 and all seg_n=7F. Holding 9 afterwards causes no push.
5. Assert reset at prescaler=2, scan_idx=2 with 3 digits valid -> after one edge, seg_n=7F, dig_n=F, digit_count=0. The next slot-0 blanking cycle follows.
6. Push 0..F sequentially, checking the slot 0 output after each push -> seg_n matches the decode list for every value.

Source files
------------

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - scrolling hex digit buffer multiplexed onto a common-anode 7-segment bank
module display_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     nibble_in,
  input  logic                           clear,
  output logic [6:0]                     seg_n,
  output logic [DIGITS-1:0]              dig_n,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

  logic [3:0]        nibble_q;
  logic [3:0]        digit [DIGITS];
  logic [DIGITS-1:0] valid;
  logic [PRE_W-1:0]  prescaler;
  logic [IDX_W-1:0]  scan_idx;
  logic              push;

  // Any change of the PIO nibble is a new digit; a held value pushes once.
  assign push = (nibble_in != nibble_q);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      4'hA:    decode = 7'h08;
      4'hB:    decode = 7'h03;
      4'hC:    decode = 7'h46;
      4'hD:    decode = 7'h21;
      4'hE:    decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      nibble_q    <= 4'h0;
      for (int i = 0; i < DIGITS; i++) digit[i] <= 4'h0;
      valid       <= '0;
      prescaler   <= '0;
      scan_idx    <= '0;
      seg_n       <= 7'h7F;
      dig_n       <= '1;
      digit_count <= '0;
    end else begin
      nibble_q <= nibble_in;

      // Clear wins over a coincident push; nibble_q still tracks so it is not replayed.
      if (clear) begin
        for (int i = 0; i < DIGITS; i++) digit[i] <= 4'h0;
        valid       <= '0;
        digit_count <= '0;
      end else if (push) begin
        digit[0] <= nibble_in;
        valid[0] <= 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
          digit[i] <= digit[i-1];
          valid[i] <= valid[i-1];
        end
        if (digit_count != CNT_MAX) digit_count <= digit_count + CNT_W'(1);
      end

      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
        scan_idx  <= (scan_idx == IDX_MAX) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end

      // First cycle of every slot is blanked so the previous digit's segments don't ghost.
      dig_n <= (prescaler == '0) ? '1 : ~(DIGITS'(1) << scan_idx);
      seg_n <= valid[scan_idx] ? decode(digit[scan_idx]) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - directed scoreboard bench for display_scan_driver (DIGITS=4, SCAN_DIV=4)
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] nibble_in = 4'h0;
  logic       clear = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic [2:0] digit_count;

  display_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .nibble_in(nibble_in), .clear(clear),
    .seg_n(seg_n), .dig_n(dig_n), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] dig_tab [10] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hB};

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_out(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Edge count since reset release; edge k sees prescaler (k-1)%4 and slot ((k-1)/4)%4.
  task automatic tick();
    @(negedge clk);
    if (reset) edges = 0;
    else edges++;
  endtask

  function automatic int phase(input int k);
    return (k - 1) % 4;
  endfunction

  function automatic int slot(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_dig(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return (phase(k) == 0) ? 4'hF : ~(one << slot(k));
  endfunction

  task automatic do_reset();
    nibble_in = 4'h0;
    clear     = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] n;
    logic [6:0] exp_seg;
    int w;

    // Reset state and idle scan.
    do_reset();
    expect_val("reset_seg", 16'h7F);          check_out({9'd0, seg_n});
    expect_val("reset_dig", 16'hF);           check_out({12'd0, dig_n});
    expect_val("reset_count", 16'd0);         check_out({13'd0, digit_count});
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i <= 10) expect_val("idle_dig_table", {12'd0, dig_tab[i-1]});
      else         expect_val("idle_dig", {12'd0, exp_dig(edges)});
      check_out({12'd0, dig_n});
      expect_val("idle_seg", 16'h7F);         check_out({9'd0, seg_n});
    end
    expect_val("idle_count", 16'd0);          check_out({13'd0, digit_count});

    // Two pushes: 3 then 7.
    do_reset();
    nibble_in = 4'h3;
    tick();
    for (int i = 0; i < 10; i++) tick();
    nibble_in = 4'h7;
    tick();
    expect_val("two_push_count", 16'd2);      check_out({13'd0, digit_count});
    for (int i = 0; i < 16; i++) begin
      tick();
      case (slot(edges))
        0:       exp_seg = 7'h78;
        1:       exp_seg = 7'h30;
        default: exp_seg = 7'h7F;
      endcase
      expect_val("two_push_seg", {9'd0, exp_seg}); check_out({9'd0, seg_n});
      expect_val("two_push_dig", {12'd0, exp_dig(edges)}); check_out({12'd0, dig_n});
    end

    // Held value pushes once, then saturation at 4.
    do_reset();
    nibble_in = 4'h5;
    for (int i = 0; i < 100; i++) tick();
    expect_val("hold_one_push", 16'd1);       check_out({13'd0, digit_count});
    nibble_in = 4'h1; tick(); expect_val("sat_count_2", 16'd2); check_out({13'd0, digit_count});
    nibble_in = 4'h2; tick(); expect_val("sat_count_3", 16'd3); check_out({13'd0, digit_count});
    nibble_in = 4'h3; tick(); expect_val("sat_count_4", 16'd4); check_out({13'd0, digit_count});
    nibble_in = 4'h4; tick(); expect_val("sat_count_4b", 16'd4); check_out({13'd0, digit_count});
    nibble_in = 4'h6; tick(); expect_val("sat_count_4c", 16'd4); check_out({13'd0, digit_count});
    for (int i = 0; i < 16; i++) begin
      tick();
      case (slot(edges))
        0:       exp_seg = 7'h02;
        1:       exp_seg = 7'h19;
        2:       exp_seg = 7'h30;
        default: exp_seg = 7'h24;
      endcase
      expect_val("sat_buffer_seg", {9'd0, exp_seg}); check_out({9'd0, seg_n});
    end

    // Clear beats a simultaneous push; the dropped change is not replayed.
    do_reset();
    nibble_in = 4'h2;
    tick();
    expect_val("pre_clear_count", 16'd1);     check_out({13'd0, digit_count});
    nibble_in = 4'h9;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_val("clear_count", 16'd0);         check_out({13'd0, digit_count});
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_val("clear_seg", 16'h7F);        check_out({9'd0, seg_n});
    end
    expect_val("clear_no_replay", 16'd0);     check_out({13'd0, digit_count});

    // Reset mid-slot with three digits valid.
    do_reset();
    nibble_in = 4'h1; tick();
    nibble_in = 4'h2; tick();
    nibble_in = 4'h3; tick();
    while (edges < 10) tick();
    expect_val("midrst_pre_count", 16'd3);    check_out({13'd0, digit_count});
    reset = 1'b1;
    nibble_in = 4'h0;
    tick();
    expect_val("midrst_seg", 16'h7F);         check_out({9'd0, seg_n});
    expect_val("midrst_dig", 16'hF);          check_out({12'd0, dig_n});
    expect_val("midrst_count", 16'd0);        check_out({13'd0, digit_count});
    reset = 1'b0;
    tick();
    expect_val("midrst_blank", 16'hF);        check_out({12'd0, dig_n});
    tick();
    expect_val("midrst_slot0", 16'hE);        check_out({12'd0, dig_n});

    // Decode of every hex value, observed in slot 0.
    do_reset();
    for (int v = 1; v <= 16; v++) begin
      n = 4'(v);
      nibble_in = n;
      tick();
      w = 0;
      do begin
        tick();
        w++;
      end while (!(phase(edges) != 0 && slot(edges) == 0) && w < 20);
      expect_val($sformatf("decode_%h", n), {9'd0, dec_tab[n]}); check_out({9'd0, seg_n});
      expect_val("decode_dig", 16'hE);        check_out({12'd0, dig_n});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
